// File: rtl/count_sum_arb_if.sv
// AXIS-style bundle between the requesters, the frame arbiter and the accumulator.
// master: arbiter view; slave: environment view (requesters plus accumulator).
interface count_sum_arb_if #(
    parameter int unsigned w = 3,
    parameter int unsigned R = 4
);
    logic [R-1:0]        s_valid;
    logic [R-1:0]        s_ready;
    logic [R-1:0][w-1:0] s_data;
    logic                m_valid;
    logic                m_ready;
    logic [w-1:0]        m_data;
    logic                m_last;
    logic [2:0]          m_id;

    modport master (
        input  s_valid,
        input  s_data,
        input  m_ready,
        output s_ready,
        output m_valid,
        output m_data,
        output m_last,
        output m_id
    );

    modport slave (
        output s_valid,
        output s_data,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  m_data,
        input  m_last,
        input  m_id
    );
endinterface

// File: rtl/count_sum_arb.sv
// Round-robin frame arbiter: locks one requester for N beats of zero-latency passthrough,
// then holds off new grants until the accumulator signals its result was consumed.
module count_sum_arb #(
    parameter int unsigned w = 3,
    parameter int unsigned N = 5,
    parameter int unsigned R = 4
) (
    input  logic            clk,
    input  logic            rst,
    count_sum_arb_if.master bus,
    input  logic            acc_done,
    output logic            busy,
    output logic [15:0]     frames
);
    localparam int unsigned IdxW     = (R > 1) ? $clog2(R) : 1;
    localparam logic [3:0]  LastBeat = 4'(N - 1);

    typedef enum logic [1:0] {StIdle, StPass, StWait} state_e;

    state_e          state_q;
    logic [IdxW-1:0] g_q;
    logic [IdxW-1:0] last_q;
    logic [IdxW-1:0] nxt;
    logic [IdxW-1:0] cand;
    logic [3:0]      beat_q;
    logic [2:0]      id_q;
    logic            found;
    logic            hs;
    logic [w-1:0]    mux_data;

    // First valid requester scanning upward from the one after the last frame owner.
    always_comb begin
        nxt   = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= R; k++) begin
            cand = IdxW'((32'(last_q) + k) % R);
            if (!found && bus.s_valid[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
    end

    assign mux_data = bus.s_data[g_q];
    assign hs       = (state_q == StPass) && bus.s_valid[g_q] && bus.m_ready;

    always_comb begin
        bus.s_ready = '0;
        bus.m_valid = 1'b0;
        bus.m_data  = '0;
        bus.m_last  = 1'b0;
        if (state_q == StPass) begin
            bus.s_ready[g_q] = bus.m_ready;
            bus.m_valid      = bus.s_valid[g_q];
            bus.m_data       = mux_data;
            bus.m_last       = (beat_q == LastBeat);
        end
    end

    assign bus.m_id = id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            g_q     <= '0;
            last_q  <= IdxW'(R - 1);
            beat_q  <= '0;
            id_q    <= '0;
            busy    <= 1'b0;
            frames  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|bus.s_valid) begin
                        g_q     <= nxt;
                        id_q    <= 3'(nxt);
                        busy    <= 1'b1;
                        state_q <= StPass;
                    end
                end
                StPass: begin
                    // Grant stays locked through valid gaps until N beats are accepted.
                    if (hs) begin
                        if (beat_q == LastBeat) begin
                            beat_q  <= '0;
                            state_q <= StWait;
                        end else begin
                            beat_q <= beat_q + 4'd1;
                        end
                    end
                end
                StWait: begin
                    if (acc_done) begin
                        last_q  <= g_q;
                        frames  <= frames + 16'd1;
                        id_q    <= '0;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_count_sum_arb.sv
// Bench for count_sum_arb: directed scenarios then random traffic, all outputs checked
// every cycle against a frame-level model (owner, beats taken, waiting flag).
module tb_count_sum_arb;
    localparam int unsigned W = 3;
    localparam int unsigned N = 5;
    localparam int unsigned R = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        acc_done = 1'b0;
    logic        busy;
    logic [15:0] frames;

    count_sum_arb_if #(.w(W), .R(R)) bus ();

    count_sum_arb #(.w(W), .N(N), .R(R)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .acc_done (acc_done),
        .busy     (busy),
        .frames   (frames)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;
    int hs_total = 0;
    int hs_cnt [R];
    bit rand_data = 1'b0;
    logic [W-1:0] pat [8] = '{3'd3, 3'd4, 3'd5, 3'd2, 3'd6, 3'd1, 3'd7, 3'd0};
    logic [W-1:0] exp031 [5] = '{3'd3, 3'd4, 3'd5, 3'd2, 3'd6};
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    logic [W-1:0] seen [$];

    // Frame-level reference: owner < 0 means no frame in progress.
    int owner = -1;
    int beats = 0;
    bit waiting = 1'b0;
    int last_g = int'(R) - 1;
    int exp_frames = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic int rr_pick(input int from, input logic [R-1:0] mask);
        for (int k = 1; k <= int'(R); k++) begin
            if (mask[(from + k) % int'(R)]) return (from + k) % int'(R);
        end
        return -1;
    endfunction

    // Called at a falling edge with inputs set; checks, updates model, advances one clock.
    task automatic cycle();
        logic [R-1:0] want_ready;
        bit pass;
        if (!rand_data) begin
            for (int i = 0; i < int'(R); i++) bus.s_data[i] = pat[hs_cnt[i] % 8] ^ W'(i ^ 2);
        end
        #1;
        pass = (owner >= 0) && !waiting;
        want_ready = '0;
        if (pass && bus.m_ready) want_ready[owner] = 1'b1;
        chk("busy", 32'(busy), 32'(owner >= 0));
        chk("m_valid", 32'(bus.m_valid), 32'(pass ? bus.s_valid[owner] : 1'b0));
        chk("s_ready", 32'(bus.s_ready), 32'(want_ready));
        chk("m_last", 32'(bus.m_last), 32'(pass && (beats == int'(N) - 1)));
        chk("m_id", 32'(bus.m_id), 32'(owner >= 0 ? owner : 0));
        chk("frames", 32'(frames), 32'(exp_frames));
        if (pass) chk("m_data", 32'(bus.m_data), 32'(bus.s_data[owner]));
        for (int i = 0; i < int'(R); i++) begin
            if (bus.s_valid[i] && bus.s_ready[i]) hs_cnt[i]++;
        end
        if (bus.m_valid && bus.m_ready) begin
            hs_total++;
            seen.push_back(bus.m_data);
        end
        if (rst) begin
            owner = -1; beats = 0; waiting = 1'b0; last_g = int'(R) - 1; exp_frames = 0;
        end else if (owner < 0) begin
            if (bus.s_valid != '0) owner = rr_pick(last_g, bus.s_valid);
        end else if (!waiting) begin
            if (bus.s_valid[owner] && bus.m_ready) begin
                beats++;
                if (beats == int'(N)) begin
                    beats = 0;
                    waiting = 1'b1;
                end
            end
        end else if (acc_done) begin
            last_g = owner;
            exp_frames = (exp_frames + 1) % 65536;
            owner = -1;
            waiting = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        bus.s_valid = '0;
        bus.s_data = '0;
        bus.m_ready = 1'b0;
        for (int i = 0; i < int'(R); i++) hs_cnt[i] = 0;
        @(posedge clk);
        @(negedge clk);
        do_reset();

        // Single requester 2, data 3,4,5,2,6.
        bus.s_valid = 4'b0100;
        bus.m_ready = 1'b1;
        seen.delete();
        cycle();
        chk("single_grant", 32'(bus.m_id), 32'd2);
        repeat (N) cycle();
        chk("single_wait_busy", 32'(busy), 32'd1);
        chk("single_beats", 32'(seen.size()), 32'd5);
        for (int k = 0; k < 5; k++) chk("single_data", 32'(seen[k]), 32'(exp031[k]));
        bus.s_valid = '0;
        acc_done = 1'b1;
        cycle();
        acc_done = 1'b0;
        chk("single_frames", 32'(frames), 32'd1);
        chk("single_idle", 32'(busy), 32'd0);

        // Round robin with all requesters valid.
        do_reset();
        bus.s_valid = '1;
        for (int f = 0; f < 5; f++) begin
            cycle();
            chk("rr_id", 32'(bus.m_id), 32'(rr_exp[f]));
            repeat (N) cycle();
            acc_done = 1'b1;
            cycle();
            acc_done = 1'b0;
        end
        chk("rr_frames", 32'(frames), 32'd5);

        // Backpressure: m_ready alternating.
        do_reset();
        bus.s_valid = 4'b0001;
        bus.m_ready = 1'b1;
        cycle();
        hs_total = 0;
        for (int k = 0; k < 9; k++) begin
            bus.m_ready = (k % 2 == 0);
            cycle();
        end
        chk("bp_handshakes", 32'(hs_total), 32'd5);
        chk("bp_wait_busy", 32'(busy), 32'd1);
        acc_done = 1'b1;
        cycle();
        acc_done = 1'b0;

        // Granted requester 0 drops valid for 3 cycles while requester 1 stays valid.
        do_reset();
        bus.s_valid = 4'b0011;
        bus.m_ready = 1'b1;
        seen.delete();
        cycle();
        repeat (2) cycle();
        bus.s_valid = 4'b0010;
        repeat (3) cycle();
        chk("gap_id", 32'(bus.m_id), 32'd0);
        bus.s_valid = 4'b0011;
        repeat (3) cycle();
        chk("gap_wait_busy", 32'(busy), 32'd1);
        chk("gap_beats", 32'(seen.size()), 32'd5);
        acc_done = 1'b1;
        cycle();
        acc_done = 1'b0;

        // Reset after beat 3, with acc_done and a handshake in the same cycle.
        do_reset();
        bus.s_valid = 4'b0110;
        cycle();
        repeat (3) cycle();
        rst = 1'b1;
        acc_done = 1'b1;
        cycle();
        rst = 1'b0;
        acc_done = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frames", 32'(frames), 32'd0);
        cycle();
        chk("rst_regrant", 32'(bus.m_id), 32'd1);

        // Stray acc_done in PASS, then in IDLE.
        acc_done = 1'b1;
        cycle();
        acc_done = 1'b0;
        chk("stray_pass_busy", 32'(busy), 32'd1);
        repeat (N - 1) cycle();
        acc_done = 1'b1;
        cycle();
        acc_done = 1'b0;
        chk("stray_frames", 32'(frames), 32'd1);
        bus.s_valid = '0;
        acc_done = 1'b1;
        cycle();
        acc_done = 1'b0;
        chk("stray_idle_busy", 32'(busy), 32'd0);
        chk("stray_idle_frames", 32'(frames), 32'd1);

        // Random traffic.
        rand_data = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            bus.s_valid = ($urandom % 4 == 0) ? '0 : R'($urandom);
            for (int i = 0; i < int'(R); i++) bus.s_data[i] = W'($urandom);
            bus.m_ready = ($urandom % 4 != 0);
            acc_done = ($urandom % 3 == 0);
            rst = ($urandom % 150 == 0);
            cycle();
        end
        rst = 1'b0;
        acc_done = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/count_sum_arb.md
COUNT_SUM_ARB -- requirements
Module: count_sum_arb

Interface
REQ-001 SHALL have parameter w, default 3, meaning beat data width.
REQ-002 SHALL have parameter N, default 5, meaning beats per frame; legal range 1..15.
REQ-003 SHALL have parameter R, default 4, meaning number of requesters; legal range 2..8.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port s_valid  input  R  per-requester AXIS valid.
REQ-007 SHALL have port s_ready  output  R  per-requester AXIS ready.
REQ-008 SHALL have port s_data  input  R x w  per-requester AXIS data, packed [R-1:0][w-1:0].
REQ-009 SHALL have port m_valid  output  1  AXIS valid toward the accumulator.
REQ-010 SHALL have port m_ready  input  1  AXIS ready from the accumulator.
REQ-011 SHALL have port m_data  output  w  muxed beat data.
REQ-012 SHALL have port m_last  output  1  high on beat N of a frame.
REQ-013 SHALL have port m_id  output  3  index of the granted requester.
REQ-014 SHALL have port acc_done  input  1  one-cycle pulse: accumulator result consumed downstream.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port frames  output  16  count of completed frames; wraps 0xFFFF->0.

Function
REQ-017 SHALL implement FSM states IDLE, PASS, WAIT.
REQ-018 IDLE: SHALL hold s_ready=0 and m_valid=0; when any s_valid is high, SHALL register grant g = first requester with s_valid high, searching round-robin from last+1 mod R, then move to PASS next cycle.
REQ-019 PASS: SHALL drive m_valid=s_valid[g], m_data=s_data[g], s_ready[g]=m_ready, and all other s_ready=0 (combinational passthrough, zero latency).
REQ-020 PASS: SHALL count handshakes (m_valid&&m_ready) in a beat counter; m_last=1 when the counter equals N-1; on the handshake with m_last=1, SHALL move to WAIT and clear the counter.
REQ-021 PASS: a requester dropping s_valid mid-frame SHALL NOT release the grant; the frame stays locked to g until N beats complete.
REQ-022 WAIT: SHALL hold all s_ready=0 and m_valid=0; on acc_done=1, SHALL set last=g, increment frames, and return to IDLE.
REQ-023 acc_done in IDLE or PASS SHALL be ignored.
REQ-024 m_id SHALL equal g in PASS and WAIT, and 0 in IDLE.
REQ-025 A grant decision SHALL take exactly one cycle in IDLE; minimum frame-to-frame spacing is N beats + 1 WAIT cycle + 1 IDLE cycle.
REQ-026 Non-granted requesters SHALL see s_ready=0 in every state; no beat from them SHALL reach m_data.
REQ-027 With N=1, the first PASS handshake SHALL assert m_last and go to WAIT.

Reset
REQ-028 On rst=1 at a clock edge, SHALL enter IDLE, clear beat counter and frames, set last=R-1 (requester 0 first priority), and drive s_ready=0, m_valid=0, m_last=0, m_id=0, busy=0.
REQ-029 rst in PASS or WAIT SHALL abort the frame with no frames increment; partial beats already passed are not recalled.
REQ-030 rst SHALL take priority over acc_done and any handshake in the same cycle.

Verification
REQ-031 Single requester: rst, then s_valid[2]=1 with data 3,4,5,2,6, m_ready=1 -> grant to 2 one cycle later, 5 beats on m_data in order, m_last on beat 5 (data 6), WAIT; acc_done -> frames=1, busy=0.
REQ-032 Round-robin: all four s_valid=1 continuously, acc_done pulsed in each WAIT -> m_id sequence 0,1,2,3,0; frames=5.
REQ-033 Backpressure: m_ready toggled 1,0,1,0... during PASS -> exactly 5 handshakes, s_ready[g] mirrors m_ready, m_data stable while m_ready=0.
REQ-034 Valid gap: granted requester drops s_valid for 3 cycles after beat 2 while requester 1 valid -> grant held, no beat from requester 1, frame completes with 5 beats.
REQ-035 Reset mid-frame: rst asserted after beat 3 -> next cycle IDLE, busy=0, m_valid=0, frames unchanged; next grant goes to lowest-index valid requester.
REQ-036 Stray acc_done: pulse in IDLE and in PASS -> no state change, frames unchanged; frames wraps 0xFFFF->0 after 65536 completed frames (force or long run).
